// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, requester ids
// and the default memory line width.
package mem_arb_pkg;

    localparam int MEM_ARB_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the I and D requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise D has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    i_req_i,
    input  logic    d_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  req_id_e last_i,
`endif
    output req_id_e winner_o
);

    always_comb begin
        winner_o = REQ_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie the side that did not win last time goes next.
        if (i_req_i && d_req_i) begin
            if (last_i == REQ_D) begin
                winner_o = REQ_I;
            end else begin
                winner_o = REQ_D;
            end
        end else if (i_req_i) begin
            winner_o = REQ_I;
        end
`else
        if (i_req_i && !d_req_i) begin
            winner_o = REQ_I;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (I-fetch / data) arbiter onto a single line-wide memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties instead of fixed D priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = MEM_ARB_LINE_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_valid,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_valid,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic                  mem_valid,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output arb_state_e            dbg_state_o
);

    localparam int OFFS = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH - OFFS){1'b1}}, {OFFS{1'b0}}};

    arb_state_e            state_q, state_d;
    req_id_e               id_q;
    req_id_e               winner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] i_rdata_q;
    logic [LINE_WIDTH-1:0] d_rdata_q;
    logic                  grant;
    logic                  issue;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_e               last_q;

    mem_arb_pick u_pick (
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .last_i   (last_q),
        .winner_o (winner)
    );
`else
    mem_arb_pick u_pick (
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .winner_o (winner)
    );
`endif

    // Requests are only sampled in IDLE; while busy, a waiting req is simply left pending.
    assign grant = (state_q == IDLE) && (i_req || d_req);
    assign issue = (state_q == ISSUE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mem_valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= REQ_D;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                id_q    <= winner;
                addr_q  <= (winner == REQ_D) ? d_addr : i_addr;
                we_q    <= (winner == REQ_D) && d_we;
                wdata_q <= (winner == REQ_D) ? d_wdata : '0;
            end
            // Writes also return a line; it lands in d_rdata like a read.
            if ((state_q == WAIT) && mem_valid) begin
                if (id_q == REQ_I) begin
                    i_rdata_q <= mem_rdata;
                end else begin
                    d_rdata_q <= mem_rdata;
                end
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= REQ_D;
        end else if (grant) begin
            last_q <= winner;
        end
    end
`endif

    assign mem_req     = issue;
    assign mem_we      = issue && we_q;
    assign mem_addr    = issue ? (addr_q & LINE_MASK) : '0;
    assign mem_wdata   = issue ? wdata_q : '0;
    assign i_valid     = (state_q == RESP) && (id_q == REQ_I);
    assign d_valid     = (state_q == RESP) && (id_q == REQ_D);
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (honours MEM_ARB_ROUND_ROBIN_EN).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int LINE_BYTES = LW / 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we, mem_valid;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, mem_rdata;
    logic          i_valid, d_valid, mem_req, mem_we, busy;
    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    arb_state_e    dbg_state;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Scoreboard and reference model state
    int            checks = 0;
    int            errors = 0;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] mem_model [logic [AW-1:0]];
    logic [LW-1:0] exp_i_rdata, exp_d_rdata;
    bit            last_was_d;
    bit            pend_i, pend_d;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, want);
        end
    endtask

    task automatic checka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic checkw(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Which side the arbitration rules say is served next.
    function automatic bit model_d_wins();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (pend_i && pend_d) return !last_was_d;
        return pend_d;
`else
        return pend_d;
`endif
    endfunction

    // Driver tasks
    task automatic new_req(input bit side_d, input bit allow_write);
        if (side_d) begin
            d_req   = 1'b1;
            d_addr  = $urandom;
            d_we    = allow_write ? 1'($urandom_range(0, 1)) : 1'b0;
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
            pend_d  = 1'b1;
        end else begin
            i_req  = 1'b1;
            i_addr = $urandom;
            pend_i = 1'b1;
        end
    endtask

    task automatic check_rdata(input string tag);
        checkw({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
        checkw({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
    endtask

    task automatic check_all_zero(input string tag);
        check1({tag, "_mem_req"}, mem_req, 1'b0);
        check1({tag, "_mem_we"}, mem_we, 1'b0);
        checka({tag, "_mem_addr"}, mem_addr, '0);
        checkw({tag, "_mem_wdata"}, mem_wdata, '0);
        check1({tag, "_i_valid"}, i_valid, 1'b0);
        check1({tag, "_d_valid"}, d_valid, 1'b0);
        checkw({tag, "_i_rdata"}, i_rdata, '0);
        checkw({tag, "_d_rdata"}, d_rdata, '0);
        check1({tag, "_busy"}, busy, 1'b0);
    endtask

    // Idle cycles with stray mem_valid noise; nothing may happen.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            mem_valid = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check1("idle_busy", busy, 1'b0);
            check1("idle_mem_req", mem_req, 1'b0);
            check1("idle_valid", i_valid | d_valid, 1'b0);
            check_rdata("idle");
        end
        mem_valid = 1'b0;
    endtask

    // One full transaction starting in an IDLE cycle with at least one req pending.
    task automatic run_grant(input int lat, input bit reissue, input bit spurious);
        bit            win_d;
        logic [AW-1:0] a, line;
        bit            we;
        logic [LW-1:0] wd, rd, want;
        win_d = model_d_wins();
        a     = win_d ? d_addr : i_addr;
        we    = win_d ? bit'(d_we) : 1'b0;
        wd    = win_d ? d_wdata : '0;
        line  = (a / LINE_BYTES) * LINE_BYTES;
        if (we) begin
            mem_model[line] = wd;
            rd = wd;
        end else begin
            if (!mem_model.exists(line)) mem_model[line] = {$urandom, $urandom, $urandom, $urandom};
            rd = mem_model[line];
        end
        exp_q.push_back(rd);
        last_was_d = win_d;

        tick();
        check1("issue_mem_req", mem_req, 1'b1);
        checka("issue_mem_addr", mem_addr, line);
        check1("issue_mem_we", mem_we, we);
        checkw("issue_mem_wdata", mem_wdata, wd);
        check1("issue_busy", busy, 1'b1);
        if (spurious) begin
            mem_valid = 1'b1;
            mem_rdata = ~rd;
        end
        for (int k = 0; k < lat; k++) begin
            tick();
            mem_valid = 1'b0;
            check1("wait_mem_req", mem_req, 1'b0);
            check1("wait_valid", i_valid | d_valid, 1'b0);
            check1("wait_busy", busy, 1'b1);
        end
        mem_valid = 1'b1;
        mem_rdata = rd;

        tick();
        mem_valid = spurious;
        mem_rdata = ~rd;
        want = exp_q.pop_front();
        if (win_d) exp_d_rdata = want;
        else exp_i_rdata = want;
        check1("resp_i_valid", i_valid, !win_d);
        check1("resp_d_valid", d_valid, win_d);
        check_rdata("resp");
        check1("resp_busy", busy, 1'b1);
        if (win_d) begin
            pend_d = 1'b0;
            if (reissue) new_req(1'b1, 1'b1);
            else d_req = 1'b0;
        end else begin
            pend_i = 1'b0;
            if (reissue) new_req(1'b0, 1'b0);
            else i_req = 1'b0;
        end

        tick();
        mem_valid = 1'b0;
        check1("post_valid", i_valid | d_valid, 1'b0);
        check1("post_busy", busy, 1'b0);
        check_rdata("post");
    endtask

    task automatic model_reset();
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        last_was_d  = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_valid = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        pend_i = 1'b0; pend_d = 1'b0;
        model_reset();
        tick();
        tick();
        check_all_zero("reset");
        checka("reset_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        idle_cycles(2);

        // Single I fetch, unaligned address, latency 5
        i_req = 1'b1; i_addr = 32'h0000_0004; pend_i = 1'b1;
        run_grant(5, 1'b0, 1'b0);

        // Simultaneous requests
        i_req = 1'b1; i_addr = 32'h0000_0200; pend_i = 1'b1;
        d_req = 1'b1; d_addr = 32'h0000_0100; d_we = 1'b0; pend_d = 1'b1;
        run_grant(3, 1'b0, 1'b0);
        run_grant(2, 1'b0, 1'b0);

        // D-side write of a known pattern
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0020; pend_d = 1'b1;
        d_wdata = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        run_grant(1, 1'b0, 1'b1);

        // Reset while in WAIT, then a late mem_valid
        i_req = 1'b1; i_addr = 32'h0000_0040; pend_i = 1'b1;
        tick();
        tick();
        check1("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_all_zero("rst_wait");
        i_req = 1'b0; pend_i = 1'b0;
        model_reset();
        tick();
        reset = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = {4{32'h5555_AAAA}};
        tick();
        mem_valid = 1'b0;
        check1("late_valid", i_valid | d_valid, 1'b0);
        checka("late_state", 32'(dbg_state), 32'(IDLE));
        idle_cycles(3);

        // Reset while in ISSUE of a write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080; d_wdata = {4{32'h1234_5678}};
        tick();
        check1("pre_reset_issue", mem_req, 1'b1);
        reset = 1'b1;
        #1;
        check_all_zero("rst_issue");
        d_req = 1'b0; d_we = 1'b0;
        model_reset();
        tick();
        reset = 1'b0;
        idle_cycles(2);

        // Both sides re-request back to back for several grants
        new_req(1'b1, 1'b0);
        new_req(1'b0, 1'b0);
        for (int g = 0; g < 4; g++) run_grant(2, 1'b1, 1'b0);
        for (int g = 0; g < 3 && (pend_i || pend_d); g++) run_grant(1, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!pend_i && !pend_d) begin
                int pick;
                idle_cycles($urandom_range(0, 2));
                pick = $urandom_range(1, 3);
                if (pick[0]) new_req(1'b0, 1'b0);
                if (pick[1]) new_req(1'b1, 1'b1);
            end else begin
                if (!pend_i && $urandom_range(0, 1) == 1) new_req(1'b0, 1'b0);
                if (!pend_d && $urandom_range(0, 1) == 1) new_req(1'b1, 1'b1);
            end
            run_grant($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int g = 0; g < 3 && (pend_i || pend_d); g++) run_grant(1, 1'b0, 1'b0);
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128, bits per memory line (power of two, >=32).
REQ-003 SHALL have port clock  input  1  single clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports i_req input 1, i_addr input ADDR_WIDTH; these form the instruction-fetch request.
REQ-006 SHALL have ports i_valid output 1, i_rdata output LINE_WIDTH; these form the instruction-fetch response.
REQ-007 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_WIDTH, d_wdata input LINE_WIDTH; these form the data request.
REQ-008 SHALL have ports d_valid output 1, d_rdata output LINE_WIDTH; these form the data response.
REQ-009 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output ADDR_WIDTH, mem_wdata output LINE_WIDTH; these form the shared memory command.
REQ-010 SHALL have ports mem_valid input 1, mem_rdata input LINE_WIDTH; these form the shared memory response (memory latency >=1 cycle).
REQ-011 SHALL have port busy  output 1  high whenever state != IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-013 In IDLE, with any req high, SHALL register the winner (id, addr, we, wdata) and go to ISSUE.
REQ-014 In IDLE, with no req, SHALL stay in IDLE.
REQ-015 ISSUE SHALL drive mem_req=1 for exactly one cycle and then go to WAIT.
REQ-016 In ISSUE, mem_addr SHALL be the latched address with its low log2(LINE_WIDTH/8) bits zeroed.
REQ-017 In ISSUE, mem_we and mem_wdata SHALL come from the latched request; mem_we=0 for I-side.
REQ-018 WAIT SHALL hold until mem_valid=1, latch mem_rdata into the winner's rdata register, then go to RESP.
REQ-019 mem_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-020 RESP SHALL pulse the winner's valid output for exactly one cycle and then go to IDLE.
REQ-021 Total latency SHALL be req seen in IDLE cycle t -> mem_req at t+1 -> x_valid one cycle after the mem_valid cycle.
REQ-022 With memory latency L (mem_valid L cycles after mem_req), x_valid SHALL occur at t+L+2.
REQ-023 Requesters hold req, addr and data stable until valid and drop req on the edge following valid; the arbiter SHALL sample reqs again only in IDLE.
REQ-024 i_rdata/d_rdata SHALL hold their last value until the next response to that side.
REQ-025 On a D-side write, d_rdata SHALL be updated with mem_rdata and d_valid SHALL still pulse.
REQ-026 Non-granted req SHALL be ignored until IDLE; there SHALL be no loss and no duplicate grant.
REQ-027 On simultaneous i_req and d_req, D SHALL win by default (fixed priority).

Reset
REQ-028 reset SHALL force IDLE and all outputs to 0 (rdata registers = 0) immediately, including mid-ISSUE/WAIT.
REQ-029 An in-flight transaction at reset SHALL be dropped with no valid pulse; its late mem_valid SHALL be ignored per REQ-019.

Configuration
REQ-030 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select arbitration policy at compile time.
REQ-031 If MEM_ARB_ROUND_ROBIN_EN is defined, on a simultaneous request the side not granted last SHALL win.
REQ-032 If MEM_ARB_ROUND_ROBIN_EN is defined, the last-granted register SHALL reset to D (I wins first tie).
REQ-033 If MEM_ARB_ROUND_ROBIN_EN is undefined, fixed D priority SHALL apply and no last-granted register SHALL exist.

Structure
REQ-034 Package mem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP), requester id enum (REQ_I/REQ_D) and default LINE_WIDTH constant.
REQ-035 Winner selection SHALL be in sub-module mem_arb_pick (combinational: i_req, d_req, last -> winner).
REQ-036 Everything else SHALL be in mem_arbiter.

Verification
REQ-037 Reset asserted mid-run -> all outputs 0, busy=0 in the same cycle, no valid pulses.
REQ-038 i_req, i_addr=0x0000_0004, memory L=5 -> mem_req at t+1, mem_addr=0x0000_0000, mem_we=0, i_valid at t+7, i_rdata=mem_rdata.
REQ-039 i_req and d_req same cycle (d_addr=0x100) -> D served first (d_valid), then I; under MEM_ARB_ROUND_ROBIN_EN I first, then D.
REQ-040 d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF... -> mem_we=1, mem_addr=0x20, mem_wdata equal to the pattern, d_valid one cycle after mem_valid.
REQ-041 Reset during WAIT, then mem_valid after reset -> no i_valid/d_valid, FSM stays IDLE.
REQ-042 d_req held continuously with i_req held -> fixed mode: I starved (documented); RR mode: grants alternate D, I, D, I.
